// File: rtl/led_pkg.sv
// Shared definitions for the switch panel / LED colour path.
package led_pkg;

    // Default geometry: one full RGB565 colour word of switches.
    localparam int unsigned WIDTH_DEFAULT     = 16;
    // 10 ms settle at 100 MHz.
    localparam int unsigned DB_CYCLES_DEFAULT = 1000000;

    // RGB565 field positions within the switch word.
    localparam int unsigned R_MSB = 15;
    localparam int unsigned R_LSB = 11;
    localparam int unsigned G_MSB = 10;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned B_MSB = 4;
    localparam int unsigned B_LSB = 0;

    localparam int unsigned R_W = R_MSB - R_LSB + 1;
    localparam int unsigned G_W = G_MSB - G_LSB + 1;
    localparam int unsigned B_W = B_MSB - B_LSB + 1;

    // Colour word as seen by the LED stage.
    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb565_t;

    // Per-bit debounce state.
    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } db_state_t;

    // Reinterpret a raw 16-bit switch word as an RGB565 colour.
    function automatic rgb565_t to_rgb565(input logic [15:0] word);
        rgb565_t c;
        c.r = word[R_MSB:R_LSB];
        c.g = word[G_MSB:G_LSB];
        c.b = word[B_MSB:B_LSB];
        return c;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, qualification counter and state.
module debounce_bit
    import led_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic out,
    output logic update_c
);

    localparam int unsigned     CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    db_state_t        state;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Strobe for the edge on which out takes the synchronised value.
    assign update_c = (state == COUNTING) && (sync2 != out) && (cnt == CNT_LAST);

    // Qualify a level change: out flips only after DB_CYCLES consecutive mismatches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE;
            cnt   <= '0;
            out   <= 1'b0;
        end else begin
            case (state)
                STABLE: begin
                    // First mismatching edge already counts as cycle one.
                    if (sync2 != out) begin
                        state <= COUNTING;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                COUNTING: begin
                    if (sync2 == out) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        out   <= sync2;
                        state <= STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Debounced switch panel: per-bit qualifiers, change strobe and startup valid.
module switch_debounce
    import led_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic             sw_changed,
    output logic             sw_valid
);

    // Startup window covers the synchroniser plus one full qualification.
    localparam int unsigned      SU_W    = $clog2(DB_CYCLES + 2);
    localparam logic [SU_W-1:0]  SU_LAST = SU_W'(DB_CYCLES + 1);
    localparam logic [SU_W-1:0]  SU_ONE  = SU_W'(1);

    logic [WIDTH-1:0] update_c;
    logic [SU_W-1:0]  su_cnt;

    // One independent qualifier per switch bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .raw      (sw_raw[i]),
            .out      (sw_out[i]),
            .update_c (update_c[i])
        );
    end

    // Registered so the pulse coincides with the new sw_out value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= |update_c;
        end
    end

    // Count cycles since reset release; valid saturates once set.
    always_ff @(posedge clk) begin
        if (rst) begin
            su_cnt   <= '0;
            sw_valid <= 1'b0;
        end else if (!sw_valid) begin
            if (su_cnt == SU_LAST) begin
                sw_valid <= 1'b1;
            end else begin
                su_cnt <= su_cnt + SU_ONE;
            end
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with a short debounce window.
module tb_switch_debounce;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DBC   = 4;
    localparam int unsigned LAT   = DBC + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_out;
    logic             sw_changed;
    logic             sw_valid;

    int total = 0;
    int bad   = 0;

    switch_debounce #(
        .WIDTH     (WIDTH),
        .DB_CYCLES (DBC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .sw_out     (sw_out),
        .sw_changed (sw_changed),
        .sw_valid   (sw_valid)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] e_out,
                             input logic e_chg, input logic e_val);
        check({tag, ".out"}, 32'(sw_out), 32'(e_out));
        check({tag, ".chg"}, 32'(sw_changed), 32'(e_chg));
        check({tag, ".val"}, 32'(sw_valid), 32'(e_val));
    endtask

    initial begin
        // Reset with all switches high.
        rst    = 1'b1;
        sw_raw = 16'hFFFF;
        step(2);
        check_all("rst", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= int'(LAT); k++) begin
            step(1);
            check_all($sformatf("boot%0d", k), (k == int'(LAT)) ? 16'hFFFF : 16'h0000,
                      k == int'(LAT), k == int'(LAT));
        end
        step(1);
        check_all("boot_after", 16'hFFFF, 1'b0, 1'b1);

        // Return to all-zero and let it settle.
        sw_raw = 16'h0000;
        step(LAT + 2);
        check_all("zero", 16'h0000, 1'b0, 1'b1);

        // Red field on: one clean update after the full latency.
        sw_raw = 16'hF800;
        for (int k = 1; k <= int'(LAT); k++) begin
            step(1);
            check_all($sformatf("red%0d", k), (k == int'(LAT)) ? 16'hF800 : 16'h0000,
                      k == int'(LAT), 1'b1);
        end
        step(1);
        check_all("red_after", 16'hF800, 1'b0, 1'b1);

        // Three-cycle glitch on bit 0 must be rejected.
        sw_raw = 16'hF801;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            check_all($sformatf("glitch_hi%0d", k), 16'hF800, 1'b0, 1'b1);
        end
        sw_raw = 16'hF800;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            check_all($sformatf("glitch_lo%0d", k), 16'hF800, 1'b0, 1'b1);
        end

        // Bounce on bit 5, then hold high.
        for (int b = 0; b < 4; b++) begin
            sw_raw = (b % 2 == 0) ? 16'hF820 : 16'hF800;
            for (int k = 1; k <= 2; k++) begin
                step(1);
                check_all($sformatf("bounce%0d_%0d", b, k), 16'hF800, 1'b0, 1'b1);
            end
        end
        sw_raw = 16'hF820;
        for (int k = 1; k <= int'(LAT); k++) begin
            step(1);
            check_all($sformatf("bsettle%0d", k), (k == int'(LAT)) ? 16'hF820 : 16'hF800,
                      k == int'(LAT), 1'b1);
        end
        step(1);
        check_all("bsettle_after", 16'hF820, 1'b0, 1'b1);

        // Bit 15 falls, bit 0 rises one cycle later: consecutive pulses.
        sw_raw = 16'h7820;
        step(1);
        check_all("pair1", 16'hF820, 1'b0, 1'b1);
        sw_raw = 16'h7821;
        for (int k = 2; k <= int'(LAT) - 1; k++) begin
            step(1);
            check_all($sformatf("pair%0d", k), 16'hF820, 1'b0, 1'b1);
        end
        step(1);
        check_all("pair_upd15", 16'h7820, 1'b1, 1'b1);
        step(1);
        check_all("pair_upd0", 16'h7821, 1'b1, 1'b1);
        step(1);
        check_all("pair_after", 16'h7821, 1'b0, 1'b1);

        // Reset while bit 10 is three cycles into counting.
        sw_raw = 16'h7C21;
        step(5);
        check_all("precount", 16'h7821, 1'b0, 1'b1);
        rst = 1'b1;
        step(1);
        check_all("midrst", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= int'(LAT); k++) begin
            step(1);
            check_all($sformatf("requal%0d", k), (k == int'(LAT)) ? 16'h7C21 : 16'h0000,
                      k == int'(LAT), k == int'(LAT));
        end
        step(1);
        check_all("requal_after", 16'h7C21, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
